// File: rtl/vga_fetch_unit.sv
// ============================================================================
//  Module   : vga_fetch_unit
//  Purpose  : Frame-buffer word fetcher with credit-limited requests feeding a
//             first-word-fall-through prefetch FIFO for the pixel serializer.
//  Options  : VGA_FETCH_UNDERFLOW_CNT_EN adds a saturating underflow counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_fetch_unit #(
   parameter int ADDR_W      = 15,
   parameter int DATA_W      = 16,
   parameter int FIFO_DEPTH  = 8,
   parameter int BASE_ADDR   = 0,
   parameter int FRAME_WORDS = 19200
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         frame_start,
   input  logic                         vga_grant,
   output logic                         vga_req,
   output logic [ADDR_W-1:0]            vga_addr,
   input  logic                         mem_valid,
   input  logic [DATA_W-1:0]            mem_data,
   input  logic                         pix_rd,
   output logic [DATA_W-1:0]            pix_data,
   output logic                         pix_valid,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
   output logic                         underflow
`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
   ,
   output logic [15:0]                  underflow_cnt
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + FRAME_WORDS - 1);
   localparam logic [LVL_W-1:0]  FULL_LEVEL = LVL_W'(FIFO_DEPTH);
   localparam logic [LVL_W:0]    CREDIT_MAX = (LVL_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   state_t              state;
   logic [LVL_W-1:0]    outstanding;
   logic [LVL_W-1:0]    outstanding_next;
   logic                accepted;
   logic [LVL_W:0]      committed;
   logic                credit_ok;

   logic [DATA_W-1:0]   storage [FIFO_DEPTH];
   logic [PTR_W-1:0]    rd_ptr;
   logic [PTR_W-1:0]    wr_ptr;
   logic                push;
   logic                pop;

   assign accepted = vga_grant && vga_req;

   // A grant and a return in the same cycle cancel; a stray return at zero is ignored.
   always_comb begin
      outstanding_next = outstanding;
      if (accepted && !mem_valid) begin
         outstanding_next = outstanding + LVL_W'(1);
      end else if (!accepted && mem_valid && (outstanding != '0)) begin
         outstanding_next = outstanding - LVL_W'(1);
      end
   end

   // Words already stored, words in flight, and the one granted right now must all fit.
   assign committed = {1'b0, fifo_level} + {1'b0, outstanding} + {{LVL_W{1'b0}}, accepted};
   assign credit_ok = (committed < CREDIT_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         vga_req     <= 1'b0;
         vga_addr    <= FIRST_ADDR;
         outstanding <= '0;
      end else begin
         outstanding <= outstanding_next;
         vga_req     <= 1'b0;

         if (frame_start) begin
            vga_addr <= FIRST_ADDR;
         end else if (accepted) begin
            vga_addr <= (vga_addr == LAST_ADDR) ? FIRST_ADDR : vga_addr + ADDR_W'(1);
         end

         case (state)
            ST_IDLE: begin
               if (frame_start) begin
                  state <= (outstanding_next != '0) ? ST_FLUSH : ST_RUN;
               end
            end
            ST_RUN: begin
               if (frame_start) begin
                  state <= (outstanding_next != '0) ? ST_FLUSH : ST_RUN;
               end else begin
                  vga_req <= credit_ok;
               end
            end
            ST_FLUSH: begin
               // Leave as soon as the last stale return has been swallowed.
               if (!frame_start && (outstanding_next == '0)) begin
                  state   <= ST_RUN;
                  vga_req <= credit_ok;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign pix_valid = (fifo_level != '0);
   assign pop       = pix_rd && pix_valid;
   assign push      = (state == ST_RUN) && mem_valid && ((fifo_level != FULL_LEVEL) || pop);
   assign pix_data  = pix_valid ? storage[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push) begin
         storage[wr_ptr] <= mem_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || frame_start) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            fifo_level <= fifo_level + LVL_W'(1);
         end else if (pop && !push) begin
            fifo_level <= fifo_level - LVL_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         underflow <= 1'b0;
      end else begin
         underflow <= pix_rd && !pix_valid;
      end
   end

`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
   // Survives frame_start so software can read a whole-session total.
   always_ff @(posedge clk) begin
      if (rst) begin
         underflow_cnt <= '0;
      end else if (pix_rd && !pix_valid && (underflow_cnt != 16'hFFFF)) begin
         underflow_cnt <= underflow_cnt + 16'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_fetch_unit.sv
// ============================================================================
//  Module   : tb_vga_fetch_unit
//  Purpose  : Randomized bench for vga_fetch_unit against a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_fetch_unit;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 8;
   localparam int FRAME  = 19200;
   localparam logic [ADDR_W-1:0] BASE = '0;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME - 1);
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_FLUSH = 2;

   logic              clk = 1'b0;
   logic              rst, frame_start, vga_grant, mem_valid, pix_rd;
   logic [DATA_W-1:0] mem_data, pix_data;
   logic              vga_req, pix_valid, underflow;
   logic [ADDR_W-1:0] vga_addr;
   logic [3:0]        fifo_level;
`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
   logic [15:0]       underflow_cnt;
`endif

   vga_fetch_unit dut (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .vga_grant   (vga_grant),
      .vga_req     (vga_req),
      .vga_addr    (vga_addr),
      .mem_valid   (mem_valid),
      .mem_data    (mem_data),
      .pix_rd      (pix_rd),
      .pix_data    (pix_data),
      .pix_valid   (pix_valid),
      .fifo_level  (fifo_level),
      .underflow   (underflow)
`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
      ,
      .underflow_cnt (underflow_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   int                m_state;
   int                m_out;
   logic [ADDR_W-1:0] m_addr;
   bit                m_req;
   bit                m_under;
   int                m_ucnt;
   logic [DATA_W-1:0] m_fifo [$];

   // Memory responder
   typedef struct {
      int                due;
      logic [ADDR_W-1:0] a;
   } ret_t;
   ret_t mq [$];
   int   cyc = 0;
   int   lat = 2;

   int                acc_seen;
   int                under_seen = 0;
   bit                wrap_seen;
   logic [ADDR_W-1:0] first_addr;

   function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
      return {a[6:0], 1'b1, a[14:7]} ^ 16'h3C5A;
   endfunction

   task automatic model_step(input bit r, input bit fs, input bit gr, input bit rd,
                             input bit mv, input logic [DATA_W-1:0] md);
      int acc, out_n, size0, st_n;
      bit credit;
      if (r) begin
         m_state = M_IDLE; m_out = 0; m_addr = BASE; m_req = 0;
         m_under = 0; m_ucnt = 0; m_fifo.delete();
         return;
      end
      acc   = (m_req && gr) ? 1 : 0;
      size0 = m_fifo.size();
      out_n = m_out;
      if (acc == 1 && !mv) out_n++;
      else if (acc == 0 && mv && m_out > 0) out_n--;
      credit  = (size0 + m_out + acc) < DEPTH;
      m_under = rd && (size0 == 0);
      if (m_under && m_ucnt < 65535) m_ucnt++;
      if (fs) m_fifo.delete();
      else begin
         if (rd && size0 > 0) void'(m_fifo.pop_front());
         if (m_state == M_RUN && mv && m_fifo.size() < DEPTH) m_fifo.push_back(md);
      end
      st_n = m_state;
      if (fs) st_n = (m_state == M_FLUSH || out_n != 0) ? M_FLUSH : M_RUN;
      else if (m_state == M_FLUSH && out_n == 0) st_n = M_RUN;
      m_req = !fs && (st_n == M_RUN) && credit;
      if (fs) m_addr = BASE;
      else if (acc == 1) m_addr = (m_addr == LAST) ? BASE : m_addr + ADDR_W'(1);
      m_out   = out_n;
      m_state = st_n;
   endtask

   task automatic compare_all();
      logic [DATA_W-1:0] head;
      head = (m_fifo.size() != 0) ? m_fifo[0] : '0;
      check("vga_req",    vga_req,    m_req);
      check("vga_addr",   vga_addr,   m_addr);
      check("pix_valid",  pix_valid,  m_fifo.size() != 0);
      check("pix_data",   pix_data,   head);
      check("fifo_level", fifo_level, m_fifo.size());
      check("underflow",  underflow,  m_under);
`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
      check("underflow_cnt", underflow_cnt, m_ucnt);
`endif
   endtask

   task automatic cycle(input bit r, input bit fs, input bit gr, input bit rd);
      bit                mv;
      logic [DATA_W-1:0] md;
      bit                dut_acc;
      logic [ADDR_W-1:0] dut_addr;
      mv = 0;
      md = DATA_W'($urandom);
      if (mq.size() != 0 && mq[0].due <= cyc) begin
         mv = 1;
         md = word_of(mq[0].a);
         void'(mq.pop_front());
      end
      rst = r; frame_start = fs; vga_grant = gr; pix_rd = rd;
      mem_valid = mv; mem_data = md;
      dut_acc  = vga_req && gr;
      dut_addr = vga_addr;
      if (dut_acc) begin
         if (acc_seen == 0) first_addr = dut_addr;
         acc_seen++;
         mq.push_back('{due: cyc + lat, a: dut_addr});
      end
      model_step(r, fs, gr, rd, mv, md);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      compare_all();
      if (underflow) under_seen++;
      if (dut_acc && !r && !fs && dut_addr == LAST) begin
         check("wrap_addr", vga_addr, BASE);
         wrap_seen = 1;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int u0, uc0;
      rst = 1; frame_start = 0; vga_grant = 0; mem_valid = 0; mem_data = '0; pix_rd = 0;
      acc_seen = 0; wrap_seen = 0; first_addr = '1;
      @(negedge clk);
      repeat (3) cycle(1, 0, 0, 0);

      // Fill with no reader: exactly DEPTH grants, then request stops.
      cycle(0, 1, 0, 0);
      acc_seen = 0;
      repeat (20) cycle(0, 0, 1, 0);
      check("fill_grants", acc_seen, DEPTH);
      check("fill_level",  fifo_level, DEPTH);
      check("fill_head",   pix_data, word_of(BASE));
      check("fill_req",    vga_req, 0);

      // Slow reader, continuous grants.
      u0 = under_seen;
      for (int i = 0; i < 200; i++) cycle(0, 0, 1, (i % 4) == 3);
      check("slow_underflows", under_seen - u0, 0);

      // Flush with 3 in flight and 5 stored.
      lat = 4;
      repeat (8) cycle(0, 0, 0, 1);
      cycle(0, 1, 0, 0);
      for (int k = 0; k < 40 && !(m_fifo.size() == 5 && m_out == 3); k++) cycle(0, 0, 1, 0);
      check("flush_setup", (m_fifo.size() == 5 && m_out == 3), 1);
      cycle(0, 1, 1, 0);
      check("flush_level", fifo_level, 0);
      check("flush_addr",  vga_addr, BASE);
      check("flush_req",   vga_req, 0);
      repeat (12) cycle(0, 0, 1, 0);

      // Three reads on an empty FIFO.
      repeat (8) cycle(0, 0, 0, 1);
      lat = 2;
      cycle(0, 1, 0, 0);
      u0  = under_seen;
      uc0 = m_ucnt;
      repeat (3) cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 0);
      check("underflow_pulses", under_seen - u0, 3);
`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
      check("underflow_cnt_total", underflow_cnt, uc0 + 3);
`endif

      // Randomized traffic with occasional frame restarts.
      lat = 3;
      for (int i = 0; i < 3000; i++)
         cycle(0, $urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      repeat (10) cycle(0, 0, 0, 1);

      // Reset with requests in flight; late returns must be dropped.
      lat = 6;
      cycle(0, 1, 0, 0);
      for (int k = 0; k < 30 && m_out < 4; k++) cycle(0, 0, 1, 0);
      check("rst_setup", m_out >= 4, 1);
      cycle(1, 0, 0, 0);
      repeat (10) cycle(0, 0, 0, 0);
      check("rst_level", fifo_level, 0);
      check("rst_req",   vga_req, 0);
      cycle(0, 1, 0, 0);
      acc_seen = 0;
      repeat (12) cycle(0, 0, 1, 0);
      check("rst_first_addr", first_addr, BASE);

      // Whole frame with a fast reader to reach the address wrap.
      repeat (10) cycle(0, 0, 0, 1);
      lat = 2;
      cycle(0, 1, 0, 0);
      wrap_seen = 0;
      for (int k = 0; k < 25000 && !wrap_seen; k++) cycle(0, 0, 1, 1);
      check("wrap_seen", wrap_seen, 1);
      repeat (5) cycle(0, 0, 1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
